// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product input and result output handshakes of the accumulator.
interface product_accumulator_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_product, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_product, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums a burst of multiplier products into a saturating accumulator
// and presents the result with a valid/ready handshake.
module product_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    product_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state, state_nx;
    logic [ACC_W-1:0]   acc, acc_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               ovf, ovf_nx;
    logic               valid_q;
    logic               in_acc, out_acc;
    logic [ACC_W:0]     sum;

    assign bus.in_ready  = (state != DONE) & ~clear;
    assign bus.out_valid = valid_q;
    assign bus.out_sum   = acc;
    assign bus.out_count = cnt;
    assign bus.out_ovf   = ovf;

    assign in_acc  = bus.in_valid & bus.in_ready;
    assign out_acc = valid_q & bus.out_ready;
    assign sum     = {1'b0, acc} + (ACC_W+1)'(bus.in_product);

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        ovf_nx   = ovf;
        if (clear) begin
            state_nx = IDLE;
            acc_nx   = '0;
            cnt_nx   = '0;
            ovf_nx   = 1'b0;
        end else begin
            case (state)
                IDLE: if (in_acc) begin
                    acc_nx   = ACC_W'(bus.in_product);
                    cnt_nx   = CNT_W'(1);
                    ovf_nx   = 1'b0;
                    state_nx = bus.in_last ? DONE : ACCUM;
                end
                ACCUM: if (in_acc) begin
                    // carry-out of the widened add means the sum no longer fits: pin to all-ones
                    acc_nx   = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
                    cnt_nx   = &cnt ? cnt : cnt + CNT_W'(1);
                    ovf_nx   = ovf | sum[ACC_W] | (&cnt);
                    state_nx = bus.in_last ? DONE : ACCUM;
                end
                DONE: state_nx = out_acc ? IDLE : DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // out_valid gets its own flop so it is not decoded from the state bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_nx;
            acc     <= acc_nx;
            cnt     <= cnt_nx;
            ovf     <= ovf_nx;
            valid_q <= (state_nx == DONE);
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed scenarios for product_accumulator with hand-computed results.
module tb_product_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    product_accumulator_if #(.PROD_W(8), .ACC_W(12), .CNT_W(5)) bus ();

    product_accumulator #(.PROD_W(8), .ACC_W(12), .CNT_W(5)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .bus  (bus.slave)
    );

    // Offer one product until it is taken; returns the number of edges it took.
    task automatic push(input logic [7:0] p, input logic l, output int edges);
        logic rdy;
        edges = 0;
        bus.in_valid = 1'b1;
        bus.in_product = p;
        bus.in_last = l;
        do begin
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            edges++;
        end while (!rdy && edges < 20);
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        if (!rdy) begin
            vectors++;
            errors++;
            $display("FAIL push_timeout: product %0d not accepted within %0d cycles", p, edges);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        vectors++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        vectors++;
        if (bus.out_sum !== 12'd0) begin errors++; $display("FAIL reset_sum: got %0d want 0", bus.out_sum); end
        vectors++;
        if (bus.out_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.out_count); end
        vectors++;
        if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", bus.out_ovf); end
    endtask

    task automatic test_single();
        int e;
        bus.out_ready = 1'b1;
        push(8'd225, 1'b1, e);
        vectors++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.out_valid); end
        vectors++;
        if (bus.out_sum !== 12'd225) begin errors++; $display("FAIL single_sum: got %0d want 225", bus.out_sum); end
        vectors++;
        if (bus.out_count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d want 1", bus.out_count); end
        vectors++;
        if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b want 0", bus.out_ovf); end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_burst4();
        int e;
        int total = 0;
        push(8'd225, 1'b0, e); total += e;
        push(8'd10, 1'b0, e);  total += e;
        push(8'd0, 1'b0, e);   total += e;
        push(8'd49, 1'b1, e);  total += e;
        vectors++;
        if (total !== 4) begin errors++; $display("FAIL burst4_cycles: got %0d want 4", total); end
        vectors++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL burst4_valid: got %b want 1", bus.out_valid); end
        vectors++;
        if (bus.out_sum !== 12'd284) begin errors++; $display("FAIL burst4_sum: got %0d want 284", bus.out_sum); end
        vectors++;
        if (bus.out_count !== 5'd4) begin errors++; $display("FAIL burst4_count: got %0d want 4", bus.out_count); end
        vectors++;
        if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL burst4_ovf: got %b want 0", bus.out_ovf); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturation();
        int e;
        for (int i = 0; i < 19; i++) push(8'd225, (i == 18), e);
        vectors++;
        if (bus.out_sum !== 12'd4095) begin errors++; $display("FAIL sat_sum: got %0d want 4095", bus.out_sum); end
        vectors++;
        if (bus.out_count !== 5'd19) begin errors++; $display("FAIL sat_count: got %0d want 19", bus.out_count); end
        vectors++;
        if (bus.out_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b want 1", bus.out_ovf); end
        @(posedge clk);
        #1;
        push(8'd3, 1'b1, e);
        vectors++;
        if (bus.out_sum !== 12'd3) begin errors++; $display("FAIL sat_next_sum: got %0d want 3", bus.out_sum); end
        vectors++;
        if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL sat_next_ovf: got %b want 0", bus.out_ovf); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_count_saturation();
        int e;
        for (int i = 0; i < 33; i++) push(8'd1, (i == 32), e);
        vectors++;
        if (bus.out_count !== 5'd31) begin errors++; $display("FAIL cnt_sat_count: got %0d want 31", bus.out_count); end
        vectors++;
        if (bus.out_sum !== 12'd33) begin errors++; $display("FAIL cnt_sat_sum: got %0d want 33", bus.out_sum); end
        vectors++;
        if (bus.out_ovf !== 1'b1) begin errors++; $display("FAIL cnt_sat_ovf: got %b want 1", bus.out_ovf); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        int e;
        bus.out_ready = 1'b0;
        push(8'd40, 1'b0, e);
        push(8'd60, 1'b1, e);
        bus.in_valid = 1'b1;
        bus.in_product = 8'd5;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
            vectors++;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.out_valid); end
            vectors++;
            if (bus.out_sum !== 12'd100) begin errors++; $display("FAIL bp_sum[%0d]: got %0d want 100", i, bus.out_sum); end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
        vectors++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_clear();
        int e;
        push(8'd50, 1'b0, e);
        push(8'd60, 1'b0, e);
        vectors++;
        if (bus.out_sum !== 12'd110) begin errors++; $display("FAIL clr_partial: got %0d want 110", bus.out_sum); end
        clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_product = 8'd9;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL clr_in_ready: got %b want 0", bus.in_ready); end
        @(posedge clk);
        #1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_sum !== 12'd0) begin errors++; $display("FAIL clr_sum: got %0d want 0", bus.out_sum); end
        vectors++;
        if (bus.out_count !== 5'd0) begin errors++; $display("FAIL clr_count: got %0d want 0", bus.out_count); end
        vectors++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL clr_valid: got %b want 0", bus.out_valid); end
        push(8'd7, 1'b1, e);
        vectors++;
        if (bus.out_sum !== 12'd7) begin errors++; $display("FAIL clr_next_sum: got %0d want 7", bus.out_sum); end
        vectors++;
        if (bus.out_count !== 5'd1) begin errors++; $display("FAIL clr_next_count: got %0d want 1", bus.out_count); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int e;
        push(8'd4, 1'b1, e);
        vectors++;
        if (bus.out_sum !== 12'd4) begin errors++; $display("FAIL b2b_first_sum: got %0d want 4", bus.out_sum); end
        push(8'd6, 1'b1, e);
        vectors++;
        if (e !== 2) begin errors++; $display("FAIL b2b_edges: got %0d want 2", e); end
        vectors++;
        if (bus.out_sum !== 12'd6) begin errors++; $display("FAIL b2b_second_sum: got %0d want 6", bus.out_sum); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        int e;
        push(8'd1, 1'b0, e);
        push(8'd2, 1'b0, e);
        push(8'd3, 1'b0, e);
        vectors++;
        if (bus.out_sum !== 12'd6) begin errors++; $display("FAIL arst_partial: got %0d want 6", bus.out_sum); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_sum !== 12'd0) begin errors++; $display("FAIL arst_sum: got %0d want 0", bus.out_sum); end
        vectors++;
        if (bus.out_count !== 5'd0) begin errors++; $display("FAIL arst_count: got %0d want 0", bus.out_count); end
        vectors++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL arst_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push(8'd5, 1'b1, e);
        vectors++;
        if (bus.out_sum !== 12'd5) begin errors++; $display("FAIL arst_next_sum: got %0d want 5", bus.out_sum); end
        vectors++;
        if (bus.out_count !== 5'd1) begin errors++; $display("FAIL arst_next_count: got %0d want 1", bus.out_count); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_product = '0;
        bus.in_last = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_single();
        test_burst4();
        test_saturation();
        test_count_saturation();
        test_backpressure();
        test_clear();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
